// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular exponentiation datapath:
// default widths, reduction cost and the exponentiation FSM states.
package rsa_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_EXP_W  = 8;
    localparam int REDUCE_CYC = 2 * DEF_DATA_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SQR,
        MUL,
        FIN
    } state_t;

endpackage

// File: rtl/mod_reduce_seq.sv
// Sequential restoring remainder: rem = dividend mod divisor.
// One load cycle plus 2*W shift-subtract steps; done flags the final step.
module mod_reduce_seq
    import rsa_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           done,
    output logic [W-1:0]   rem
);

    localparam int CW = $clog2(2 * W) + 1;
    localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

    logic           busy;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] dvd;
    logic [W-1:0]   div;
    logic [W-1:0]   r;
    logic [W:0]     trial;
    logic [W-1:0]   r_nxt;

    // One restoring step; partial remainder stays below divisor,
    // so the shifted trial value needs only one extra bit.
    always_comb begin
        trial = {r, dvd[2*W-1]};
        r_nxt = trial[W-1:0];
        if (trial >= {1'b0, div}) begin
            r_nxt = W'(trial - {1'b0, div});
        end
    end

    assign done = busy && (cnt == LAST);
    assign rem  = r_nxt;

    // Operand load on start, then one quotient bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
            dvd  <= '0;
            div  <= '0;
            r    <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            dvd  <= dividend;
            div  <= divisor;
            r    <= '0;
        end else if (busy) begin
            r   <= r_nxt;
            dvd <= {dvd[2*W-2:0], 1'b0};
            cnt <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mod_exp_seq.sv
// Left-to-right square-and-multiply modular exponentiation engine.
// Every modular product is reduced by the shared sequential reducer.
module mod_exp_seq
    import rsa_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int EXP_W  = DEF_EXP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] base,
    input  logic [EXP_W-1:0]  exponent,
    input  logic [DATA_W-1:0] modulus,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(EXP_W - 1);

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   base_r;
    logic [DATA_W-1:0]   mod_r;
    logic [EXP_W-1:0]    exp_r;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   b;
    logic [IW-1:0]       idx;
    logic                red_run;
    logic                red_start;
    logic                red_done;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   op;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] dividend;
    logic                accept;
    logic                mod_zero;
    logic                bit_set;
    logic                last_bit;
    logic                step;

    assign ready    = (state == IDLE);
    assign accept   = start && ready;
    assign mod_zero = (mod_r == '0);
    assign bit_set  = exp_r[idx];
    assign last_bit = (idx == '0);
    assign step     = ((state == SQR) && !bit_set) || (state == MUL);

    // Kick the reducer once on entry to each reducing state;
    // a zero modulus never starts a reduction.
    assign red_start = !red_run &&
                       (((state == PRE) && !mod_zero) ||
                        (state == SQR) || (state == MUL));

    // Full-width product so nothing is lost before reduction.
    always_comb begin
        op       = (state == SQR) ? acc : b;
        prod     = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, op};
        dividend = prod;
        if (state == PRE) begin
            dividend = {{DATA_W{1'b0}}, base_r};
        end
    end

    mod_reduce_seq #(
        .W(DATA_W)
    ) u_reduce (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (red_start),
        .dividend (dividend),
        .divisor  (mod_r),
        .done     (red_done),
        .rem      (rem)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: walk exponent bits MSB first.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = PRE;
            PRE: begin
                if (mod_zero) begin
                    state_nxt = FIN;
                end else if (red_done) begin
                    state_nxt = SQR;
                end
            end
            SQR: begin
                if (red_done) begin
                    if (bit_set) begin
                        state_nxt = MUL;
                    end else if (last_bit) begin
                        state_nxt = FIN;
                    end
                end
            end
            MUL: begin
                if (red_done) begin
                    state_nxt = last_bit ? FIN : SQR;
                end
            end
            FIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tracks an in-flight reduction so each state starts only one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_run <= 1'b0;
        end else if (red_start) begin
            red_run <= 1'b1;
        end else if (red_done) begin
            red_run <= 1'b0;
        end
    end

    // Operand capture, accumulator/bit-index updates and result publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r <= '0;
            mod_r  <= '0;
            exp_r  <= '0;
            acc    <= '0;
            b      <= '0;
            idx    <= '0;
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                base_r <= base;
                exp_r  <= exponent;
                mod_r  <= modulus;
                acc    <= DATA_W'(1);
                idx    <= IDX_TOP;
                result <= '0;
                err    <= 1'b0;
            end
            if (red_done) begin
                if (state == PRE) begin
                    b <= rem;
                end else begin
                    acc <= rem;
                end
            end
            if (red_done && step && !last_bit) begin
                idx <= idx - IW'(1);
            end
            if (state == FIN) begin
                done   <= 1'b1;
                result <= mod_zero ? '0 : acc;
                err    <= mod_zero;
            end
        end
    end

endmodule
